// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank and the word-select mux it feeds:
// geometry constants, FSM encoding and the flat-bus word extraction helper.
package reg_bank_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NBYTES = WIDTH / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Word i sits at bits 16*i+15:16*i, so sel=i returns register i.
  function automatic logic [WIDTH-1:0] word_of(input logic [DEPTH*WIDTH-1:0] q,
                                               input logic [ADDR_W-1:0]      sel);
    return q[WIDTH*sel +: WIDTH];
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Write/clear request bus and register-bank status outputs, grouped as one
// interface with a master (requester) and slave (bank) view.
interface reg_bank_if;
  import reg_bank_pkg::*;

  logic                    wr_req;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [NBYTES-1:0]       byte_en;
  logic                    clr_req;
  logic [DEPTH*WIDTH-1:0]  Q;
  logic [DEPTH-1:0]        valid;
  logic                    busy;
  logic                    wr_ack;
  logic                    wr_err;

  modport master (
    output wr_req, wr_addr, wr_data, byte_en, clr_req,
    input  Q, valid, busy, wr_ack, wr_err
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, byte_en, clr_req,
    output Q, valid, busy, wr_ack, wr_err
  );

endinterface

// File: rtl/reg_word.sv
// One register word with per-byte write enables and a synchronous clear that
// takes priority over any write in the same cycle.
module reg_word
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBYTES-1:0] i_we,
  input  logic              i_clr,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: every word is reset because Q must read all-zero the moment rst_n
  // drops; non-blocking assignments keep all words updating on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_we[b]) r_q[8*b +: 8] <= i_data[8*b +: 8];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank.sv
// 8 x 16-bit register bank: byte-enabled write port with ack/err pulses and a
// one-entry-per-cycle clear engine that rejects writes while it runs.
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  reg_bank_if.slave  bus
);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [ADDR_W-1:0]              r_clr_ptr;
  logic [DEPTH-1:0]               r_valid;
  logic                           r_wr_ack;
  logic                           r_wr_err;

  logic                           w_accept;
  logic                           w_reject;
  logic [DEPTH-1:0]               w_clr_hit;
  logic [DEPTH-1:0][NBYTES-1:0]   w_we;
  logic [DEPTH-1:0][WIDTH-1:0]    w_words;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_clr_hit    = '0;
    w_we         = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          w_next_state = ST_CLEAR;
          w_reject     = bus.wr_req;
        end else begin
          w_accept     = bus.wr_req;
        end
      end
      ST_CLEAR: begin
        w_reject             = bus.wr_req;
        w_clr_hit[r_clr_ptr] = 1'b1;
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_accept) w_we[bus.wr_addr] = bus.byte_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_ptr <= '0;
      r_valid   <= '0;
      r_wr_ack  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_wr_ack  <= w_accept;
      r_wr_err  <= w_reject;
      // Pointer sits at 0 in IDLE so a new clear always starts at word 0.
      r_clr_ptr <= (r_state == ST_CLEAR) ? r_clr_ptr + 1'b1 : '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_clr_hit[i])      r_valid[i] <= 1'b0;
        else if (|w_we[i])     r_valid[i] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    reg_word u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_we[g]),
      .i_clr  (w_clr_hit[g]),
      .i_data (bus.wr_data),
      .o_q    (w_words[g])
    );
  end

  assign bus.Q      = w_words;
  assign bus.valid  = r_valid;
  assign bus.busy   = (r_state == ST_CLEAR);
  assign bus.wr_ack = r_wr_ack;
  assign bus.wr_err = r_wr_err;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: table of single-cycle write vectors plus
// hand-written clear, collision and reset-mid-clear sequences.
module tb_reg_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  reg_bank_if bus ();

  reg_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [7:0]  exp_valid;
    logic [15:0] exp_word;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [2:0] addr, input logic [15:0] data,
                       input logic [1:0] be, input logic clr);
    bus.wr_req  = wr;
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.byte_en = be;
    bus.clr_req = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word(input int i);
    return bus.Q[16*i +: 16];
  endfunction

  task automatic set_vec(input int idx, input logic wr, input logic [2:0] addr,
                         input logic [15:0] data, input logic [1:0] be,
                         input logic [7:0] ev, input logic [15:0] ew, input logic ea);
    vecs[idx].wr = wr;           vecs[idx].addr = addr;
    vecs[idx].data = data;       vecs[idx].be = be;
    vecs[idx].exp_valid = ev;    vecs[idx].exp_word = ew;
    vecs[idx].exp_ack = ea;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check(name, {127'b0, bus.busy}, 128'd0);
  endtask

  initial begin
    set_vec( 0, 1'b1, 3'd0, 16'hFFFF, 2'b00, 8'h00, 16'h0000, 1'b1);
    set_vec( 1, 1'b1, 3'd0, 16'hFFFF, 2'b11, 8'h01, 16'hFFFF, 1'b1);
    set_vec( 2, 1'b1, 3'd1, 16'hFFFF, 2'b11, 8'h03, 16'hFFFF, 1'b1);
    set_vec( 3, 1'b1, 3'd2, 16'hFFFF, 2'b11, 8'h07, 16'hFFFF, 1'b1);
    set_vec( 4, 1'b1, 3'd3, 16'hFFFF, 2'b11, 8'h0F, 16'hFFFF, 1'b1);
    set_vec( 5, 1'b1, 3'd4, 16'hFFFF, 2'b11, 8'h1F, 16'hFFFF, 1'b1);
    set_vec( 6, 1'b1, 3'd5, 16'hFFFF, 2'b11, 8'h3F, 16'hFFFF, 1'b1);
    set_vec( 7, 1'b1, 3'd6, 16'hFFFF, 2'b11, 8'h7F, 16'hFFFF, 1'b1);
    set_vec( 8, 1'b1, 3'd7, 16'hFFFF, 2'b11, 8'hFF, 16'hFFFF, 1'b1);
    set_vec( 9, 1'b1, 3'd3, 16'h1234, 2'b11, 8'hFF, 16'h1234, 1'b1);
    set_vec(10, 1'b1, 3'd3, 16'hABCD, 2'b01, 8'hFF, 16'h12CD, 1'b1);
    set_vec(11, 1'b1, 3'd3, 16'h5678, 2'b10, 8'hFF, 16'h56CD, 1'b1);
    set_vec(12, 1'b1, 3'd3, 16'h9999, 2'b00, 8'hFF, 16'h56CD, 1'b1);
    set_vec(13, 1'b0, 3'd3, 16'h0000, 2'b11, 8'hFF, 16'h56CD, 1'b0);

    // Reset with random inputs
    drive(1'($urandom), 3'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
    repeat (3) tick();
    check("rst_q",     bus.Q, 128'd0);
    check("rst_valid", {120'b0, bus.valid}, 128'd0);
    check("rst_busy",  {127'b0, bus.busy}, 128'd0);
    check("rst_ack",   {127'b0, bus.wr_ack}, 128'd0);
    check("rst_err",   {127'b0, bus.wr_err}, 128'd0);
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();

    // Walking write and byte lanes
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, 1'b0);
      tick();
      check($sformatf("v%0d_ack", i),   {127'b0, bus.wr_ack}, {127'b0, vecs[i].exp_ack});
      check($sformatf("v%0d_err", i),   {127'b0, bus.wr_err}, 128'd0);
      check($sformatf("v%0d_valid", i), {120'b0, bus.valid}, {120'b0, vecs[i].exp_valid});
      check($sformatf("v%0d_word", i),  {112'b0, word(int'(vecs[i].addr))}, {112'b0, vecs[i].exp_word});
      check($sformatf("v%0d_busy", i),  {127'b0, bus.busy}, 128'd0);
    end
    check("walk_q", bus.Q, 128'hFFFF_FFFF_FFFF_FFFF_56CD_FFFF_FFFF_FFFF);
    for (int i = 0; i < 8; i++)
      check($sformatf("mux_sel%0d", i), {112'b0, reg_bank_pkg::word_of(bus.Q, 3'(i))},
            {112'b0, (i == 3) ? 16'h56CD : 16'hFFFF});

    // Clear sequence
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'hA5A5, 2'b11, 1'b0);
      tick();
    end
    check("fill_q", bus.Q, {8{16'hA5A5}});
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
    tick();
    check("clr_busy_rise", {127'b0, bus.busy}, 128'd1);
    check("clr_word0_held", {112'b0, word(0)}, {112'b0, 16'hA5A5});
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 3'd0, 16'h0, 2'b00, k == 3);
      tick();
      check($sformatf("clr%0d_busy", k), {127'b0, bus.busy}, {127'b0, k < 7});
      check($sformatf("clr%0d_word", k), {112'b0, word(k)}, 128'd0);
      if (k < 7)
        check($sformatf("clr%0d_next", k), {112'b0, word(k + 1)}, {112'b0, 16'hA5A5});
      check($sformatf("clr%0d_valid", k), {120'b0, bus.valid}, {120'b0, 8'(8'hFF << (k + 1))});
    end
    check("clr_q", bus.Q, 128'd0);
    tick();
    check("clr_no_restart", {127'b0, bus.busy}, 128'd0);

    // Clear/write collision
    drive(1'b1, 3'd2, 16'h5555, 2'b11, 1'b1);
    tick();
    check("col0_err", {127'b0, bus.wr_err}, 128'd1);
    check("col0_ack", {127'b0, bus.wr_ack}, 128'd0);
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
    repeat (4) tick();
    check("col_err_quiet", {127'b0, bus.wr_err}, 128'd0);
    drive(1'b1, 3'd2, 16'h5555, 2'b11, 1'b0);
    tick();
    check("col1_err", {127'b0, bus.wr_err}, 128'd1);
    check("col1_ack", {127'b0, bus.wr_ack}, 128'd0);
    check("col1_word2", {112'b0, word(2)}, 128'd0);
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
    wait_idle("col_clear_done");
    check("col_word2_end", {112'b0, word(2)}, 128'd0);
    check("col_valid_end", {120'b0, bus.valid}, 128'd0);

    // byte_en=00 on an unwritten entry leaves valid clear
    drive(1'b1, 3'd5, 16'h7777, 2'b00, 1'b0);
    tick();
    check("be00_ack", {127'b0, bus.wr_ack}, 128'd1);
    check("be00_valid", {120'b0, bus.valid}, 128'd0);
    check("be00_word5", {112'b0, word(5)}, 128'd0);

    // Reset mid-clear
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'h1111, 2'b11, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
    tick();
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
    repeat (4) tick();
    check("mid_busy_pre", {127'b0, bus.busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", bus.Q, 128'd0);
    check("mid_rst_busy", {127'b0, bus.busy}, 128'd0);
    check("mid_rst_valid", {120'b0, bus.valid}, 128'd0);
    #2 rst_n = 1'b1;
    drive(1'b1, 3'd7, 16'hBEEF, 2'b11, 1'b0);
    tick();
    check("post_ack", {127'b0, bus.wr_ack}, 128'd1);
    check("post_q", bus.Q, {16'hBEEF, 112'b0});
    check("post_valid", {120'b0, bus.valid}, 128'h80);
    drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
    tick();
    check("post_busy", {127'b0, bus.busy}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
